// File: rtl/pcileech_tlps128_cfg_requester.sv
// Configuration-request initiator on the 128-bit TLP path (clk_pcie domain).
// Accepts one command, emits a single CfgRd0/1 or CfgWr0/1 TLP, then waits
// for the matching Cpl/CplD or a timeout and reports the result with a
// one-cycle strobe. One request is outstanding at a time; the tag rolls by
// one after every response.
module pcileech_tlps128_cfg_requester #(
   parameter int TIMEOUT_CYCLES = 62500,
   parameter int TMO_W          = 16
) (
   input  logic          clk_pcie,
   input  logic          rst_n,
   input  logic [15:0]   pcie_id,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic          req_type1,
   input  logic [15:0]   req_bdf,
   input  logic [9:0]    req_reg,
   input  logic [3:0]    req_be,
   input  logic [31:0]   req_data,
   output logic [127:0]  tx_tdata,
   output logic [3:0]    tx_tkeepdw,
   output logic          tx_tlast,
   output logic          tx_tvalid,
   input  logic          tx_tready,
   input  logic [127:0]  rx_tdata,
   input  logic          rx_tuser0,
   input  logic          rx_tvalid,
   output logic          rsp_valid,
   output logic [2:0]    rsp_status,
   output logic          rsp_timeout,
   output logic [31:0]   rsp_data,
   output logic [15:0]   stale_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [7:0]       FT_CPL   = 8'h0A;
   localparam logic [7:0]       FT_CPLD  = 8'h4A;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t             state_q,       state_d;
   logic [7:0]         tag_q,         tag_d;
   logic [TMO_W-1:0]   cnt_q,         cnt_d;
   logic               req_ready_q,   req_ready_d;
   logic               tx_tvalid_q,   tx_tvalid_d;
   logic [127:0]       tx_tdata_q,    tx_tdata_d;
   logic [3:0]         tx_tkeepdw_q,  tx_tkeepdw_d;
   logic               rsp_valid_q,   rsp_valid_d;
   logic [2:0]         rsp_status_q,  rsp_status_d;
   logic               rsp_timeout_q, rsp_timeout_d;
   logic [31:0]        rsp_data_q,    rsp_data_d;
   logic [15:0]        stale_cnt_q,   stale_cnt_d;

   // Completion decode: header fields of the first beat of an incoming TLP.
   logic [7:0]  rx_ft;
   logic        rx_is_cpl;
   logic        cpl_hit;
   logic        cpl_stale;
   logic [7:0]  fmt_type;

   assign rx_ft     = rx_tdata[31:24];
   assign rx_is_cpl = rx_tvalid && rx_tuser0 && (rx_ft == FT_CPL || rx_ft == FT_CPLD);
   assign cpl_hit   = rx_is_cpl && (state_q == ST_WAIT)
                      && (rx_tdata[95:80] == pcie_id) && (rx_tdata[79:72] == tag_q);
   assign cpl_stale = rx_is_cpl && !cpl_hit;

   // CfgRd0 = 0x04, CfgRd1 = 0x05; the write variants add the data bit (0x40).
   assign fmt_type = {1'b0, req_wr, 5'b00010, req_type1};

   // Header bits that play no part in matching or status extraction.
   logic unused_rx;
   assign unused_rx = ^{rx_tdata[71:48], rx_tdata[44:32], rx_tdata[23:0]};

   // Next-state and next-output computation for the request sequencer.
   // NOTE: every variable gets its default (hold) value first so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      tag_d         = tag_q;
      cnt_d         = cnt_q;
      tx_tdata_d    = tx_tdata_q;
      tx_tkeepdw_d  = tx_tkeepdw_q;
      rsp_valid_d   = 1'b0;
      rsp_status_d  = rsp_status_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_data_d    = rsp_data_q;
      stale_cnt_d   = stale_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d      = ST_SEND;
               tx_tdata_d   = {req_wr ? req_data : 32'h0,
                               req_bdf, 4'b0000, req_reg[9:6], req_reg[5:0], 2'b00,
                               pcie_id, tag_q, 4'b0000, req_be,
                               fmt_type, 14'h0, 10'd1};
               tx_tkeepdw_d = req_wr ? 4'b1111 : 4'b0111;
            end
         end
         ST_SEND: begin
            if (tx_tvalid_q && tx_tready) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A completion arriving on the terminal-count cycle still wins.
            if (cpl_hit) begin
               state_d       = ST_RESP;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_status_d  = rx_tdata[47:45];
               rsp_data_d    = (rx_ft == FT_CPLD) ? rx_tdata[127:96] : 32'h0;
            end else if (cnt_q == TMO_LAST) begin
               state_d       = ST_RESP;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_status_d  = 3'b000;
               rsp_data_d    = 32'h0;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            tag_d   = tag_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (cpl_stale && stale_cnt_q != 16'hFFFF)
         stale_cnt_d = stale_cnt_q + 16'd1;
   end

   assign req_ready_d = (state_d == ST_IDLE);
   assign tx_tvalid_d = (state_d == ST_SEND);

   // State and registered outputs; reset aborts any request in flight.
   // NOTE: non-blocking assignments here so every flop samples the values
   // computed before the edge, independent of statement order.
   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         tag_q         <= 8'h00;
         cnt_q         <= '0;
         req_ready_q   <= 1'b0;
         tx_tvalid_q   <= 1'b0;
         tx_tdata_q    <= 128'h0;
         tx_tkeepdw_q  <= 4'b0111;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= 3'b000;
         rsp_timeout_q <= 1'b0;
         rsp_data_q    <= 32'h0;
         stale_cnt_q   <= 16'h0000;
      end else begin
         state_q       <= state_d;
         tag_q         <= tag_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         tx_tvalid_q   <= tx_tvalid_d;
         tx_tdata_q    <= tx_tdata_d;
         tx_tkeepdw_q  <= tx_tkeepdw_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_status_q  <= rsp_status_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_data_q    <= rsp_data_d;
         stale_cnt_q   <= stale_cnt_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign tx_tdata    = tx_tdata_q;
   assign tx_tkeepdw  = tx_tkeepdw_q;
   assign tx_tlast    = 1'b1;
   assign tx_tvalid   = tx_tvalid_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_data    = rsp_data_q;
   assign stale_cnt   = stale_cnt_q;

endmodule

// File: tb/tb_pcileech_tlps128_cfg_requester.sv
// Directed bench for pcileech_tlps128_cfg_requester with a short timeout.
module tb_pcileech_tlps128_cfg_requester;

   localparam int TMO = 100;

   logic          clk_pcie = 1'b0;
   logic          rst_n;
   logic [15:0]   pcie_id;
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic          req_type1;
   logic [15:0]   req_bdf;
   logic [9:0]    req_reg;
   logic [3:0]    req_be;
   logic [31:0]   req_data;
   logic [127:0]  tx_tdata;
   logic [3:0]    tx_tkeepdw;
   logic          tx_tlast;
   logic          tx_tvalid;
   logic          tx_tready;
   logic [127:0]  rx_tdata;
   logic          rx_tuser0;
   logic          rx_tvalid;
   logic          rsp_valid;
   logic [2:0]    rsp_status;
   logic          rsp_timeout;
   logic [31:0]   rsp_data;
   logic [15:0]   stale_cnt;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int hs_cyc = 0;
   logic [127:0] exp_td;

   pcileech_tlps128_cfg_requester #(.TIMEOUT_CYCLES(TMO), .TMO_W(16)) dut (
      .clk_pcie   (clk_pcie),
      .rst_n      (rst_n),
      .pcie_id    (pcie_id),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_type1  (req_type1),
      .req_bdf    (req_bdf),
      .req_reg    (req_reg),
      .req_be     (req_be),
      .req_data   (req_data),
      .tx_tdata   (tx_tdata),
      .tx_tkeepdw (tx_tkeepdw),
      .tx_tlast   (tx_tlast),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .rx_tdata   (rx_tdata),
      .rx_tuser0  (rx_tuser0),
      .rx_tvalid  (rx_tvalid),
      .rsp_valid  (rsp_valid),
      .rsp_status (rsp_status),
      .rsp_timeout(rsp_timeout),
      .rsp_data   (rsp_data),
      .stale_cnt  (stale_cnt)
   );

   always #5 clk_pcie = ~clk_pcie;

   // Edge counter and index of the edge on which the TLP handshake occurred.
   always @(posedge clk_pcie) begin
      cyc <= cyc + 1;
      if (tx_tvalid && tx_tready) hs_cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] cpl(input logic [7:0] ft, input logic [15:0] rid,
                                        input logic [7:0] tg, input logic [2:0] st,
                                        input logic [31:0] dat);
      logic [127:0] d;
      d          = 128'h0;
      d[31:24]   = ft;
      d[9:0]     = (ft == 8'h4A) ? 10'd1 : 10'd0;
      d[47:45]   = st;
      d[95:80]   = rid;
      d[79:72]   = tg;
      d[127:96]  = dat;
      return d;
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk_pcie);
      #1;
   endtask

   task automatic issue(input logic wr, input logic t1, input logic [15:0] bdf,
                        input logic [9:0] rg, input logic [3:0] be, input logic [31:0] dat);
      int i = 0;
      while (!req_ready && i < 50) begin
         tick();
         i++;
      end
      check("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_type1 = t1;
      req_bdf   = bdf;
      req_reg   = rg;
      req_be    = be;
      req_data  = dat;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send_cpl(input logic [127:0] d, input logic first);
      rx_tdata  = d;
      rx_tuser0 = first;
      rx_tvalid = 1'b1;
      tick();
      rx_tvalid = 1'b0;
      rx_tuser0 = 1'b0;
      rx_tdata  = 128'h0;
   endtask

   task automatic wait_rsp(input int bound);
      int i = 0;
      while (!rsp_valid && i < bound) begin
         tick();
         i++;
      end
      check("rsp_seen", rsp_valid, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; pcie_id = 16'h0200; req_valid = 1'b0; req_wr = 1'b0;
      req_type1 = 1'b0; req_bdf = 16'h0; req_reg = 10'h0; req_be = 4'h0;
      req_data = 32'h0; tx_tready = 1'b1; rx_tdata = 128'h0; rx_tuser0 = 1'b0;
      rx_tvalid = 1'b0;

      // Reset state.
      #23;
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_tx_tvalid", tx_tvalid, 1'b0);
      check("rst_tx_tlast", tx_tlast, 1'b1);
      check("rst_tkeepdw", tx_tkeepdw, 4'b0111);
      check("rst_tx_tdata", tx_tdata, 128'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_stale", stale_cnt, 16'h0);
      @(negedge clk_pcie);
      rst_n = 1'b1;
      tick();
      check("ready_after_release", req_ready, 1'b1);

      // CfgRd0, tag 0, answered by CplD.
      issue(1'b0, 1'b0, 16'h0108, 10'h001, 4'hF, 32'h0);
      check("rd0_tvalid", tx_tvalid, 1'b1);
      check("rd0_ready_low", req_ready, 1'b0);
      check("rd0_dw0", tx_tdata[31:0], 32'h04000001);
      check("rd0_dw1", tx_tdata[63:32], 32'h0200000F);
      check("rd0_dw2", tx_tdata[95:64], 32'h01080004);
      check("rd0_dw3", tx_tdata[127:96], 32'h0);
      check("rd0_keep", tx_tkeepdw, 4'b0111);
      tick();
      check("rd0_tvalid_done", tx_tvalid, 1'b0);
      send_cpl(cpl(8'h4A, 16'h0200, 8'd0, 3'b000, 32'h12345678), 1'b1);
      wait_rsp(0);
      check("rd0_status", rsp_status, 3'b000);
      check("rd0_timeout", rsp_timeout, 1'b0);
      check("rd0_data", rsp_data, 32'h12345678);
      tick();
      check("rd0_rsp_one_cycle", rsp_valid, 1'b0);
      check("rd0_data_hold", rsp_data, 32'h12345678);

      // CfgWr1, tag 1, answered by Cpl with UR.
      issue(1'b1, 1'b1, 16'h0108, 10'h3FF, 4'h3, 32'hCAFEBABE);
      check("wr1_dw0", tx_tdata[31:0], 32'h45000001);
      check("wr1_dw1", tx_tdata[63:32], 32'h02000103);
      check("wr1_dw2", tx_tdata[95:64], 32'h01080FFC);
      check("wr1_dw3", tx_tdata[127:96], 32'hCAFEBABE);
      check("wr1_keep", tx_tkeepdw, 4'b1111);
      tick();
      send_cpl(cpl(8'h0A, 16'h0200, 8'd1, 3'b001, 32'hDEADBEEF), 1'b1);
      wait_rsp(0);
      check("wr1_status", rsp_status, 3'b001);
      check("wr1_data", rsp_data, 32'h0);
      tick();

      // Backpressure, tag 2: TLP held stable, new command ignored.
      tx_tready = 1'b0;
      issue(1'b0, 1'b0, 16'h0300, 10'h010, 4'h1, 32'h0);
      exp_td = {32'h0, 32'h03000040, 32'h02000201, 32'h04000001};
      req_valid = 1'b1; req_wr = 1'b1; req_bdf = 16'hFFFF; req_reg = 10'h155;
      req_be = 4'hA; req_data = 32'h99999999;
      for (int i = 0; i < 10; i++) begin
         check("bp_tdata", tx_tdata, exp_td);
         check("bp_tvalid", tx_tvalid, 1'b1);
         check("bp_ready", req_ready, 1'b0);
         tick();
      end
      req_valid = 1'b0;
      tx_tready = 1'b1;
      tick();
      check("bp_released", tx_tvalid, 1'b0);
      send_cpl(cpl(8'h4A, 16'h0200, 8'd2, 3'b000, 32'hA5A5A5A5), 1'b1);
      wait_rsp(0);
      check("bp_data", rsp_data, 32'hA5A5A5A5);
      tick();
      check("bp_no_extra_tlp", tx_tvalid, 1'b0);

      // Timeout, tag 3.
      issue(1'b0, 1'b0, 16'h0108, 10'h002, 4'hF, 32'h0);
      wait_rsp(TMO + 20);
      check("tmo_latency", 128'(cyc - hs_cyc), 128'd100);
      check("tmo_flag", rsp_timeout, 1'b1);
      check("tmo_status", rsp_status, 3'b000);
      check("tmo_data", rsp_data, 32'h0);
      tick();
      send_cpl(cpl(8'h4A, 16'h0200, 8'd3, 3'b000, 32'h11111111), 1'b1);
      check("late_cpl_stale", stale_cnt, 16'd1);
      check("late_cpl_no_rsp", rsp_valid, 1'b0);
      send_cpl(cpl(8'h40, 16'h0200, 8'd4, 3'b000, 32'h0), 1'b1);
      check("non_cpl_not_counted", stale_cnt, 16'd1);

      // Tag 4: wrong tag / wrong requester / non-first beat ignored first.
      issue(1'b0, 1'b0, 16'h0108, 10'h003, 4'hF, 32'h0);
      check("tag4_dw1", tx_tdata[63:32], 32'h0200040F);
      tick();
      send_cpl(cpl(8'h4A, 16'h0200, 8'd5, 3'b000, 32'h1), 1'b1);
      check("wrong_tag_stale", stale_cnt, 16'd2);
      check("wrong_tag_no_rsp", rsp_valid, 1'b0);
      send_cpl(cpl(8'h4A, 16'h0300, 8'd4, 3'b000, 32'h2), 1'b1);
      check("wrong_rid_stale", stale_cnt, 16'd3);
      send_cpl(cpl(8'h4A, 16'h0200, 8'd4, 3'b000, 32'h3), 1'b0);
      check("not_first_ignored", rsp_valid, 1'b0);
      send_cpl(cpl(8'h4A, 16'h0200, 8'd4, 3'b000, 32'h55AA55AA), 1'b1);
      wait_rsp(0);
      check("tag4_data", rsp_data, 32'h55AA55AA);
      check("tag4_stale_kept", stale_cnt, 16'd3);
      tick();

      // Tag 5: match on the terminal-count cycle beats the timeout.
      issue(1'b0, 1'b0, 16'h0108, 10'h004, 4'hF, 32'h0);
      tick();
      while (cyc < hs_cyc + TMO - 1) tick();
      send_cpl(cpl(8'h4A, 16'h0200, 8'd5, 3'b010, 32'h0BADF00D), 1'b1);
      wait_rsp(0);
      check("term_latency", 128'(cyc - hs_cyc), 128'd100);
      check("term_timeout", rsp_timeout, 1'b0);
      check("term_status", rsp_status, 3'b010);
      check("term_data", rsp_data, 32'h0BADF00D);
      tick();

      // Tags 6..255, then the tag wraps to 0.
      for (int k = 6; k < 256; k++) begin
         logic [7:0] tg;
         tg = k[7:0];
         issue(1'b0, 1'b0, 16'h0108, 10'h005, 4'hF, 32'h0);
         tick();
         send_cpl(cpl(8'h0A, 16'h0200, tg, 3'b000, 32'h0), 1'b1);
         wait_rsp(0);
         tick();
      end
      issue(1'b0, 1'b0, 16'h0108, 10'h006, 4'hF, 32'h0);
      check("tag_wrap", tx_tdata[47:40], 8'h00);
      tick();
      send_cpl(cpl(8'h4A, 16'h0200, 8'd0, 3'b000, 32'h77777777), 1'b1);
      wait_rsp(0);
      check("wrap_data", rsp_data, 32'h77777777);
      tick();

      // Tag 1 aborted by reset during SEND.
      tx_tready = 1'b0;
      issue(1'b0, 1'b0, 16'h0108, 10'h007, 4'hF, 32'h0);
      check("abort_tag", tx_tdata[47:40], 8'h01);
      check("abort_tvalid_before", tx_tvalid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_tvalid_async", tx_tvalid, 1'b0);
      check("abort_ready_low", req_ready, 1'b0);
      tx_tready = 1'b1;
      @(negedge clk_pcie);
      rst_n = 1'b1;
      tick();
      check("abort_ready_release", req_ready, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("abort_no_rsp", rsp_valid, 1'b0);
         tick();
      end
      send_cpl(cpl(8'h4A, 16'h0200, 8'd1, 3'b000, 32'h88888888), 1'b1);
      check("abort_late_stale", stale_cnt, 16'd1);
      issue(1'b0, 1'b0, 16'h0108, 10'h008, 4'hF, 32'h0);
      check("abort_tag_reset", tx_tdata[47:40], 8'h00);
      tick();
      send_cpl(cpl(8'h4A, 16'h0200, 8'd0, 3'b000, 32'h13579BDF), 1'b1);
      wait_rsp(0);
      check("abort_next_data", rsp_data, 32'h13579BDF);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
